// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer: command-driven load / up / down stepping counter.
// A command is accepted in IDLE. The counter is preloaded, then stepped once
// per clock with modular wrap until it reaches the latched target.
// Completion is reported with a one-cycle done pulse and an abort with a
// one-cycle aborted pulse.
module updown_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] target_q;
  logic             up_q;
  logic             done_q;
  logic             aborted_q;
  logic [WIDTH-1:0] step_d;

  // Next count for a run step. Wrap falls out of the fixed-width add/subtract.
  always_comb begin
    step_d = up_q ? (count_q + ONE) : (count_q - ONE);
  end

  // Sequencer FSM. The done and aborted pulses are registered with the state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      target_q  <= '0;
      up_q      <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OP_LOAD: begin
                count_q <= cmd_start;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
              OP_UP, OP_DOWN: begin
                count_q  <= cmd_start;
                up_q     <= (cmd_op == OP_UP);
                target_q <= cmd_target;
                if (cmd_start == cmd_target) begin
                  // Zero-step run completes immediately.
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_RUN;
                end
              end
              default: ; // reserved op: accepted and dropped
            endcase
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort wins over the step, including the terminal step.
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
          end else begin
            count_q <= step_d;
            if (step_d == target_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // cmd_ready and busy decode the state register only.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign count     = count_q;
  assign up        = up_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Bench for updown_count_sequencer. Each accepted run is expanded into its
// full count trajectory. A compare process checks every output on every
// falling clock edge. Directed steps also pin literal hand-computed values.
module tb_updown_count_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_target = '0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         up, busy, done, aborted;

  int checks = 0;
  int failures = 0;

  updown_count_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .resetb(resetb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_start(cmd_start), .cmd_target(cmd_target),
    .abort(abort), .count(count), .up(up), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Model: expected outputs plus the queue of counts still to be stepped.
  logic [W-1:0] e_count = '0;
  logic         e_up = 1'b1, e_ready = 1'b1, e_busy = 1'b0;
  logic         e_done = 1'b0, e_aborted = 1'b0;
  logic [W-1:0] traj[$];

  always @(posedge clk or negedge resetb) begin
    logic         prev_done;
    logic [W-1:0] k;
    if (!resetb) begin
      e_count = '0; e_up = 1'b1; e_ready = 1'b1; e_busy = 1'b0;
      e_done = 1'b0; e_aborted = 1'b0;
      traj.delete();
    end else begin
      prev_done = e_done;
      e_done = 1'b0;
      e_aborted = 1'b0;
      if (traj.size() > 0) begin
        if (abort) begin
          traj.delete();
          e_aborted = 1'b1; e_busy = 1'b0; e_ready = 1'b1;
        end else begin
          e_count = traj.pop_front();
          if (traj.size() == 0) begin
            e_busy = 1'b0; e_done = 1'b1;
          end
        end
      end else if (prev_done) begin
        e_ready = 1'b1;
      end else if (cmd_valid) begin
        if (cmd_op == 2'b00) begin
          e_count = cmd_start; e_done = 1'b1; e_ready = 1'b0;
        end else if (cmd_op != 2'b11) begin
          e_count = cmd_start;
          e_up = (cmd_op == 2'b01);
          k = e_up ? cmd_target - cmd_start : cmd_start - cmd_target;
          for (int i = 1; i <= int'(k); i++)
            traj.push_back(e_up ? cmd_start + W'(i) : cmd_start - W'(i));
          e_ready = 1'b0;
          if (k == 0) e_done = 1'b1;
          else e_busy = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    cmp("count", int'(count), int'(e_count));
    cmp("up", int'(up), int'(e_up));
    cmp("cmd_ready", int'(cmd_ready), int'(e_ready));
    cmp("busy", int'(busy), int'(e_busy));
    cmp("done", int'(done), int'(e_done));
    cmp("aborted", int'(aborted), int'(e_aborted));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a command and hold it until accepted. Returns 1 ns after the
  // accept edge. The payload is then scrambled to show it is sampled once.
  task automatic send(input logic [1:0] op, input logic [W-1:0] s,
                      input logic [W-1:0] t);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_start = s; cmd_target = t;
    for (int c = 0; c < 100 && !acc; c++) begin
      acc = cmd_ready;
      tick();
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: op %0d not accepted within 100 cycles", op);
    end
    cmd_valid = 1'b0; cmd_start = ~s; cmd_target = ~t; cmd_op = 2'b00;
  endtask

  initial begin
    #2;
    cmp("rst_count", int'(count), 0);
    cmp("rst_ready", int'(cmd_ready), 1);
    #10 resetb = 1'b1;
    tick();

    // LOAD 9
    send(2'b00, 4'd9, 4'd0);
    cmp("load_count", int'(count), 9);
    cmp("load_done", int'(done), 1);
    tick();
    cmp("load_ready_back", int'(cmd_ready), 1);

    // UP 3 -> 7
    send(2'b01, 4'd3, 4'd7);
    cmp("up_first", int'(count), 3);
    cmp("up_busy", int'(busy), 1);
    repeat (4) tick();
    cmp("up_last", int'(count), 7);
    cmp("up_done", int'(done), 1);
    tick();
    cmp("up_ready_back", int'(cmd_ready), 1);

    // DOWN 2 -> 14 with wrap
    send(2'b10, 4'd2, 4'd14);
    cmp("down_dir", int'(up), 0);
    repeat (2) tick();
    cmp("down_wrap0", int'(count), 0);
    tick();
    cmp("down_wrap15", int'(count), 15);
    tick();
    cmp("down_done", int'(done), 1);
    tick();

    // UP 14 -> 1 with wrap
    send(2'b01, 4'd14, 4'd1);
    repeat (2) tick();
    cmp("upwrap_0", int'(count), 0);
    tick();
    cmp("upwrap_done", int'(done), 1);
    tick();

    // Zero-step run
    send(2'b01, 4'd9, 4'd9);
    cmp("zero_done", int'(done), 1);
    cmp("zero_count", int'(count), 9);
    tick();

    // Full-cycle run: 15 steps
    send(2'b01, 4'd5, 4'd4);
    repeat (14) tick();
    cmp("full_not_done", int'(done), 0);
    tick();
    cmp("full_count", int'(count), 4);
    cmp("full_done", int'(done), 1);
    tick();

    // Abort mid-run at count 5
    send(2'b01, 4'd0, 4'd10);
    repeat (5) tick();
    cmp("abort_pre", int'(count), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("abort_hold", int'(count), 5);
    cmp("abort_pulse", int'(aborted), 1);
    cmp("abort_ready", int'(cmd_ready), 1);
    cmp("abort_nodone", int'(done), 0);
    tick();

    // Abort on the would-be terminal step
    send(2'b01, 4'd0, 4'd10);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("abort_term_count", int'(count), 9);
    cmp("abort_term_pulse", int'(aborted), 1);
    tick();

    // Command held during RUN waits for cmd_ready
    send(2'b01, 4'd0, 4'd3);
    send(2'b01, 4'd1, 4'd2);
    cmp("held_count", int'(count), 1);
    cmp("held_busy", int'(busy), 1);
    repeat (3) tick();

    // Reserved op: no state change
    send(2'b11, 4'd7, 4'd0);
    cmp("rsv_count", int'(count), 2);
    cmp("rsv_ready", int'(cmd_ready), 1);

    // Abort in IDLE is ignored
    abort = 1'b1;
    repeat (2) tick();
    cmp("idle_abort", int'(aborted), 0);
    abort = 1'b0;

    // Asynchronous reset mid-run at count 6
    send(2'b10, 4'd12, 4'd0);
    repeat (6) tick();
    cmp("prerst_count", int'(count), 6);
    #2 resetb = 1'b0;
    #1;
    cmp("arst_count", int'(count), 0);
    cmp("arst_up", int'(up), 1);
    cmp("arst_busy", int'(busy), 0);
    cmp("arst_ready", int'(cmd_ready), 1);
    #3 resetb = 1'b1;
    repeat (3) tick();
    cmp("post_rst_done", int'(done), 0);
    cmp("post_rst_aborted", int'(aborted), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
